// File: rtl/sdram_arb_pkg.sv
// Shared types and default geometry for the SDRAM frame arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

  localparam int DEF_FRAME_WORDS = 307200;
  localparam int DEF_BURST_LEN   = 256;
  localparam int DEF_BUF1_BASE   = 32'h0020_0000;

endpackage

// File: rtl/sdram_frame_arbiter_frame_buf_sel.sv
// Double-buffer bookkeeping: latches camera/VGA frame-start events, applies
// them when the arbiter is idle, selects the write/read buffers and emits
// the FIFO flush pulses.
module frame_buf_sel (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cam_start_i,
  input  logic vga_start_i,
  input  logic idle_i,
  input  logic wr_frame_full_i,
  output logic pending_o,
  output logic cam_apply_o,
  output logic vga_apply_o,
  output logic wr_flush_o,
  output logic rd_flush_o,
  output logic wr_buf_o,
  output logic rd_buf_o
);

  logic pend_cam_q, pend_cam_d;
  logic pend_vga_q, pend_vga_d;
  logic wr_buf_q, wr_buf_d;
  logic rd_buf_q, rd_buf_d;
  logic last_full_q, last_full_d;
  logic wr_flush_q, rd_flush_q;

  assign cam_apply_o = idle_i & pend_cam_q;
  assign vga_apply_o = idle_i & pend_vga_q;
  assign pending_o   = pend_cam_q | pend_vga_q;

  // Event latching and buffer swap; the camera event is resolved first so the
  // VGA side picks up a frame completed in the very same cycle.
  always_comb begin
    pend_cam_d  = (pend_cam_q & ~cam_apply_o) | cam_start_i;
    pend_vga_d  = (pend_vga_q & ~vga_apply_o) | vga_start_i;
    wr_buf_d    = wr_buf_q;
    last_full_d = last_full_q;
    rd_buf_d    = rd_buf_q;
    if (cam_apply_o && wr_frame_full_i) begin
      last_full_d = wr_buf_q;
      wr_buf_d    = ~wr_buf_q;
    end
    if (vga_apply_o) begin
      rd_buf_d = last_full_d;
    end
  end

  // State registers plus one-cycle flush pulses marking each applied event.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_cam_q  <= 1'b0;
      pend_vga_q  <= 1'b0;
      wr_buf_q    <= 1'b0;
      rd_buf_q    <= 1'b0;
      last_full_q <= 1'b0;
      wr_flush_q  <= 1'b0;
      rd_flush_q  <= 1'b0;
    end else begin
      pend_cam_q  <= pend_cam_d;
      pend_vga_q  <= pend_vga_d;
      wr_buf_q    <= wr_buf_d;
      rd_buf_q    <= rd_buf_d;
      last_full_q <= last_full_d;
      wr_flush_q  <= cam_apply_o;
      rd_flush_q  <= vga_apply_o;
    end
  end

  assign wr_flush_o = wr_flush_q;
  assign rd_flush_o = rd_flush_q;
  assign wr_buf_o   = wr_buf_q;
  assign rd_buf_o   = rd_buf_q;

endmodule

// File: rtl/sdram_frame_arbiter.sv
// SDRAM burst arbiter between the camera write FIFO and the VGA read FIFO.
// One burst is in flight at a time; frames are double-buffered so the display
// always reads the last completed camera frame.
// Optional statistics (urgent_cnt, wr_overrun) are built when ARB_STATS_EN
// is defined.
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W       = 22,
  parameter int LVL_W        = 10,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int FRAME_WORDS  = DEF_FRAME_WORDS,
  parameter int BUF1_BASE    = DEF_BUF1_BASE,
  parameter int RD_LOW_WATER = 128,
  parameter int FIFO_DEPTH   = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cam_frame_start,
  input  logic              vga_frame_start,
  input  logic [LVL_W-1:0]  wr_fifo_level,
  input  logic [LVL_W-1:0]  rd_fifo_level,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [8:0]        cmd_len,
  input  logic              cmd_done,
  output logic              wr_flush,
  output logic              rd_flush,
  output logic              wr_buf,
  output logic              rd_buf
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       urgent_cnt,
  output logic              wr_overrun
`endif
);

  localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BUF1_A  = ADDR_W'(BUF1_BASE);
  localparam logic [LVL_W:0]    BURST_L = (LVL_W+1)'(BURST_LEN);
  localparam logic [LVL_W:0]    LOW_L   = (LVL_W+1)'(RD_LOW_WATER);
  localparam logic [LVL_W:0]    DEPTH_L = (LVL_W+1)'(FIFO_DEPTH);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;

  logic              idle;
  logic              evt_pending;
  logic              cam_apply;
  logic              vga_apply;
  logic              wr_frame_full;
  logic              sel_wr_buf;
  logic              sel_rd_buf;
  logic [LVL_W:0]    wr_lvl;
  logic [LVL_W:0]    rd_lvl;
  logic [LVL_W:0]    rd_space;
  logic              wr_open;
  logic              rd_open;
  logic              urgent_rd;
  logic              want_wr;
  logic              want_rd;
  logic [ADDR_W-1:0] wr_base;
  logic [ADDR_W-1:0] rd_base;

  // Offsets stop at the end of the frame; there is no wrap within a frame.
  function automatic logic [ADDR_W-1:0] sat_advance(input logic [ADDR_W-1:0] a);
    if (a >= FRAME_A - BURST_A) begin
      return FRAME_A;
    end
    return a + BURST_A;
  endfunction

  assign idle          = (state_q == IDLE);
  assign wr_frame_full = (wr_addr_q == FRAME_A);

  frame_buf_sel u_buf_sel (
    .clk_i           (CLK),
    .rst_i           (RST),
    .cam_start_i     (cam_frame_start),
    .vga_start_i     (vga_frame_start),
    .idle_i          (idle),
    .wr_frame_full_i (wr_frame_full),
    .pending_o       (evt_pending),
    .cam_apply_o     (cam_apply),
    .vga_apply_o     (vga_apply),
    .wr_flush_o      (wr_flush),
    .rd_flush_o      (rd_flush),
    .wr_buf_o        (sel_wr_buf),
    .rd_buf_o        (sel_rd_buf)
  );

  assign wr_lvl    = {1'b0, wr_fifo_level};
  assign rd_lvl    = {1'b0, rd_fifo_level};
  assign rd_space  = DEPTH_L - rd_lvl;
  assign wr_open   = (wr_addr_q < FRAME_A);
  assign rd_open   = (rd_addr_q < FRAME_A);
  assign urgent_rd = (rd_lvl < LOW_L) && rd_open;
  assign want_wr   = (wr_lvl >= BURST_L) && wr_open;
  assign want_rd   = (rd_space >= BURST_L) && rd_open;
  assign wr_base   = sel_wr_buf ? BUF1_A : '0;
  assign rd_base   = sel_rd_buf ? BUF1_A : '0;

  // Command FSM: frame events take the idle cycle, otherwise arbitrate and
  // register the chosen burst; addresses advance once the burst completes.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    unique case (state_q)
      IDLE: begin
        if (evt_pending) begin
          if (cam_apply) wr_addr_d = '0;
          if (vga_apply) rd_addr_d = '0;
        end else if (urgent_rd) begin
          cmd_write_d = 1'b0;
          cmd_addr_d  = rd_base + rd_addr_q;
          state_d     = ISSUE;
        end else if (want_wr) begin
          cmd_write_d = 1'b1;
          cmd_addr_d  = wr_base + wr_addr_q;
          state_d     = ISSUE;
        end else if (want_rd) begin
          cmd_write_d = 1'b0;
          cmd_addr_d  = rd_base + rd_addr_q;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) state_d = BUSY;
      end
      BUSY: begin
        if (cmd_done) begin
          if (cmd_write_q) wr_addr_d = sat_advance(wr_addr_q);
          else             rd_addr_d = sat_advance(rd_addr_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, address counter and command field registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
    end
  end

  assign cmd_valid = (state_q == ISSUE);
  assign cmd_write = cmd_write_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = 9'(BURST_LEN);
  assign wr_buf    = sel_wr_buf;
  assign rd_buf    = sel_rd_buf;

`ifdef ARB_STATS_EN
  logic        urgent_grant;
  logic [15:0] urgent_cnt_q;
  logic        wr_overrun_q;

  assign urgent_grant = idle && !evt_pending && urgent_rd;

  // Saturating urgent-read grant counter and sticky camera FIFO overrun flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      urgent_cnt_q <= '0;
      wr_overrun_q <= 1'b0;
    end else begin
      if (urgent_grant && (urgent_cnt_q != 16'hFFFF)) begin
        urgent_cnt_q <= urgent_cnt_q + 16'd1;
      end
      if (wr_lvl == DEPTH_L - 1'b1) begin
        wr_overrun_q <= 1'b1;
      end
    end
  end

  assign urgent_cnt = urgent_cnt_q;
  assign wr_overrun = wr_overrun_q;
`endif

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Self-checking bench for sdram_frame_arbiter: the bench plays the SDRAM
// controller, a transaction-level model predicts every command and buffer
// selection, and directed phases pin key values with literals.
module tb_sdram_frame_arbiter;

  localparam int FRAME = 307200;
  localparam int BURST = 256;
  localparam int BUF1  = 32'h0020_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cam_frame_start;
  logic        vga_frame_start;
  logic [9:0]  wr_fifo_level;
  logic [9:0]  rd_fifo_level;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [21:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        cmd_done;
  logic        wr_flush;
  logic        rd_flush;
  logic        wr_buf;
  logic        rd_buf;
`ifdef ARB_STATS_EN
  logic [15:0] urgent_cnt;
  logic        wr_overrun;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  bit abortFlag = 0;

  // Model state, owned by the compare process
  int m_wr_addr, m_rd_addr;
  bit m_wr_buf, m_rd_buf, m_last_full;
  bit m_pend_cam, m_pend_vga;
  bit m_inflight, m_inflight_wr;

  sdram_frame_arbiter dut (
    .CLK             (CLK),
    .RST             (RST),
    .cam_frame_start (cam_frame_start),
    .vga_frame_start (vga_frame_start),
    .wr_fifo_level   (wr_fifo_level),
    .rd_fifo_level   (rd_fifo_level),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .cmd_done        (cmd_done),
    .wr_flush        (wr_flush),
    .rd_flush        (rd_flush),
    .wr_buf          (wr_buf),
    .rd_buf          (rd_buf)
`ifdef ARB_STATS_EN
    ,
    .urgent_cnt      (urgent_cnt),
    .wr_overrun      (wr_overrun)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Arbitration rules applied to the model's offsets and the present levels
  function automatic void predictCmd(output bit grant, output bit isWr, output logic [21:0] addr);
    int wl, rl, base;
    wl = int'(wr_fifo_level);
    rl = int'(rd_fifo_level);
    grant = 1'b1;
    isWr  = 1'b0;
    addr  = '0;
    if (rl < 128 && m_rd_addr < FRAME) begin
      base = m_rd_buf ? BUF1 : 0;
      addr = 22'(base + m_rd_addr);
    end else if (wl >= BURST && m_wr_addr < FRAME) begin
      isWr = 1'b1;
      base = m_wr_buf ? BUF1 : 0;
      addr = 22'(base + m_wr_addr);
    end else if (1024 - rl >= BURST && m_rd_addr < FRAME) begin
      base = m_rd_buf ? BUF1 : 0;
      addr = 22'(base + m_rd_addr);
    end else begin
      grant = 1'b0;
    end
  endfunction

  // Compare process: update the model and check outputs every cycle
  always @(negedge CLK) begin : compareProc
    bit eg, ew;
    logic [21:0] ea;
    if (RST) begin
      m_wr_addr = 0; m_rd_addr = 0;
      m_wr_buf = 0; m_rd_buf = 0; m_last_full = 0;
      m_pend_cam = 0; m_pend_vga = 0; m_inflight = 0; m_inflight_wr = 0;
    end else begin
      if (wr_flush || rd_flush) checkOutput("no_cmd_in_apply_cycle", 32'(cmd_valid), 32'd0);
      if (wr_flush) begin
        checkOutput("wr_flush_has_event", 32'(wr_flush), 32'(m_pend_cam));
        if (m_wr_addr == FRAME) begin
          m_last_full = m_wr_buf;
          m_wr_buf = !m_wr_buf;
        end
        m_wr_addr = 0;
        m_pend_cam = 0;
      end
      if (rd_flush) begin
        checkOutput("rd_flush_has_event", 32'(rd_flush), 32'(m_pend_vga));
        m_rd_buf = m_last_full;
        m_rd_addr = 0;
        m_pend_vga = 0;
      end
      if (cam_frame_start) m_pend_cam = 1;
      if (vga_frame_start) m_pend_vga = 1;
      checkOutput("wr_buf", 32'(wr_buf), 32'(m_wr_buf));
      checkOutput("rd_buf", 32'(rd_buf), 32'(m_rd_buf));
      if (cmd_valid) begin
        predictCmd(eg, ew, ea);
        checkOutput("cmd_grant", 32'(cmd_valid), 32'(eg));
        if (eg) begin
          checkOutput("cmd_write", 32'(cmd_write), 32'(ew));
          checkOutput("cmd_addr", 32'(cmd_addr), 32'(ea));
          checkOutput("cmd_len", 32'(cmd_len), 32'(BURST));
          if (cmd_ready) begin
            m_inflight = 1;
            m_inflight_wr = ew;
          end
        end
      end
      if (cmd_done && m_inflight) begin
        if (m_inflight_wr) m_wr_addr = (m_wr_addr + BURST > FRAME) ? FRAME : m_wr_addr + BURST;
        else               m_rd_addr = (m_rd_addr + BURST > FRAME) ? FRAME : m_rd_addr + BURST;
        m_inflight = 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input int wl, input int rl);
    wr_fifo_level = 10'(wl);
    rd_fifo_level = 10'(rl);
  endtask

  // Serve one burst as the controller; optionally fire both frame events in BUSY
  task automatic doBurst(input bit pulseBusy);
    int n = 0;
    while (!cmd_valid && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_valid) begin
      checkOutput("burst_timeout", 32'(cmd_valid), 32'd1);
      abortFlag = 1;
      return;
    end
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    if (pulseBusy) begin
      cam_frame_start = 1;
      vga_frame_start = 1;
      tick();
      cam_frame_start = 0;
      vga_frame_start = 0;
    end
    tick();
    cmd_done = 1;
    tick();
    cmd_done = 0;
  endtask

  task automatic writeFrame();
    int n = 0;
    while (m_wr_addr < FRAME && n < 1300 && !abortFlag) begin
      doBurst(0);
      n++;
    end
  endtask

  task automatic frameEvent(input bit isCam);
    int n = 0;
    if (isCam) cam_frame_start = 1;
    else       vga_frame_start = 1;
    tick();
    cam_frame_start = 0;
    vga_frame_start = 0;
    do begin
      tick();
      n++;
    end while (!(isCam ? wr_flush : rd_flush) && n < 10);
    if (isCam) checkOutput("wr_flush_seen", 32'(wr_flush), 32'd1);
    else       checkOutput("rd_flush_seen", 32'(rd_flush), 32'd1);
  endtask

  task automatic expectCmd(input string name, input bit isWr, input int addr);
    checkOutput({name, "_valid"}, 32'(cmd_valid), 32'd1);
    checkOutput({name, "_write"}, 32'(cmd_write), 32'(isWr));
    checkOutput({name, "_addr"}, 32'(cmd_addr), 32'(addr));
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainProc
    RST = 1;
    cam_frame_start = 0;
    vga_frame_start = 0;
    cmd_ready = 0;
    cmd_done = 0;
    applyStimulus(256, 1000);
    repeat (3) tick();
    checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst_cmd_write", 32'(cmd_write), 32'd0);
    checkOutput("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    checkOutput("rst_wr_flush", 32'(wr_flush), 32'd0);
    checkOutput("rst_rd_flush", 32'(rd_flush), 32'd0);
    checkOutput("rst_wr_buf", 32'(wr_buf), 32'd0);
    checkOutput("rst_rd_buf", 32'(rd_buf), 32'd0);

    // First write issued one cycle after the first IDLE cycle
    RST = 0;
    tick();
    expectCmd("first_write", 1, 0);
    doBurst(0);
    tick();
    expectCmd("second_write", 1, 256);
    doBurst(0);

    // Urgent read beats a pending write
    applyStimulus(300, 50);
    tick();
    expectCmd("urgent_read", 0, 0);
    doBurst(0);
    applyStimulus(300, 1000);
    tick();
    expectCmd("write_after_read", 1, 512);
    doBurst(0);

    // Low-water boundary: 128 is not urgent, 127 is
    applyStimulus(300, 128);
    tick();
    expectCmd("lvl128_write", 1, 768);
    doBurst(0);
    applyStimulus(300, 127);
    tick();
    expectCmd("lvl127_read", 0, 256);
    doBurst(0);

    // 255 words is not a full burst and the read FIFO has no room
    applyStimulus(255, 1000);
    repeat (3) begin
      tick();
      checkOutput("no_grant_idle", 32'(cmd_valid), 32'd0);
    end

    // Complete frame into buffer 0, then swap
    applyStimulus(300, 1000);
    writeFrame();
    repeat (3) begin
      tick();
      checkOutput("write_saturated", 32'(cmd_valid), 32'd0);
    end
    applyStimulus(0, 1000);
    frameEvent(1);
    checkOutput("frame1_wr_buf", 32'(wr_buf), 32'd1);
    frameEvent(0);
    checkOutput("frame1_rd_buf", 32'(rd_buf), 32'd0);

    // Partial frame into buffer 1 keeps the buffer choice
    applyStimulus(300, 1000);
    tick();
    expectCmd("buf1_first_write", 1, BUF1);
    for (int i = 0; i < 10 && !abortFlag; i++) doBurst(0);
    applyStimulus(0, 1000);
    frameEvent(1);
    checkOutput("partial_wr_buf", 32'(wr_buf), 32'd1);
    frameEvent(0);
    checkOutput("partial_rd_buf", 32'(rd_buf), 32'd0);

    // Complete frame into buffer 1; display moves to buffer 1
    applyStimulus(300, 1000);
    writeFrame();
    applyStimulus(0, 1000);
    frameEvent(1);
    checkOutput("frame2_wr_buf", 32'(wr_buf), 32'd0);
    frameEvent(0);
    checkOutput("frame2_rd_buf", 32'(rd_buf), 32'd1);
    applyStimulus(0, 50);
    tick();
    expectCmd("buf1_read", 0, BUF1);
    doBurst(0);

    // Stalled handshake keeps the command stable
    applyStimulus(300, 1000);
    tick();
    expectCmd("stall_start", 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expectCmd("stall_hold", 1, 0);
    end

    // Frame events during BUSY are applied after cmd_done, without a command
    doBurst(1);
    tick();
    checkOutput("busy_evt_wr_flush", 32'(wr_flush), 32'd1);
    checkOutput("busy_evt_rd_flush", 32'(rd_flush), 32'd1);
    checkOutput("busy_evt_no_cmd", 32'(cmd_valid), 32'd0);
    tick();
    checkOutput("busy_evt_wr_flush_end", 32'(wr_flush), 32'd0);
    checkOutput("busy_evt_rd_flush_end", 32'(rd_flush), 32'd0);
    expectCmd("after_partial_restart", 1, 0);
    checkOutput("busy_evt_rd_buf", 32'(rd_buf), 32'd1);

    // Reset while a burst is in flight
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    RST = 1;
    tick();
    checkOutput("busy_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    checkOutput("busy_rst_cmd_write", 32'(cmd_write), 32'd0);
    checkOutput("busy_rst_cmd_addr", 32'(cmd_addr), 32'd0);
    checkOutput("busy_rst_wr_flush", 32'(wr_flush), 32'd0);
    checkOutput("busy_rst_rd_flush", 32'(rd_flush), 32'd0);
    checkOutput("busy_rst_wr_buf", 32'(wr_buf), 32'd0);
    checkOutput("busy_rst_rd_buf", 32'(rd_buf), 32'd0);
    RST = 0;
    tick();
    expectCmd("post_rst_write", 1, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
